// File: rtl/switch_debouncer_if.sv
// Bundle for the switch conditioning stage: the raw pin levels going in and
// the clean levels, change pulses and settled flag coming out.
interface switch_debouncer_if #(
  parameter int N_SW = 3
);
  logic [N_SW-1:0] sw_raw;
  logic [N_SW-1:0] sw_db;
  logic [N_SW-1:0] sw_chg;
  logic            all_stable;

  modport master (output sw_raw, input sw_db, sw_chg, all_stable);
  modport slave  (input sw_raw, output sw_db, sw_chg, all_stable);
endinterface

// File: rtl/switch_debouncer.sv
// Per-channel synchroniser plus bounce filter for the SWITCH x1/x2/x3 inputs;
// a channel's debounced level only follows a synchronised level held long enough.
module switch_debouncer_lane #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic db_o,
  output logic chg_o,
  output logic counting_o
);
  typedef enum logic {IDLE, COUNT} state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic             chg_q, chg_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      chg_q   <= chg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    chg_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sync2_q != db_q) begin
          state_d = COUNT;
          cnt_d   = CNT_W'(1);
        end
      end
      COUNT: begin
        // A single matching sample is a bounce: qualification restarts.
        if (sync2_q == db_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          db_d    = sync2_q;
          chg_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign db_o       = db_q;
  assign chg_o      = chg_q;
  // Next-state view so the settled flag reflects the state after this edge.
  assign counting_o = (state_d == COUNT);
endmodule

module switch_debouncer #(
  parameter int N_SW          = 3,
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input logic          clk,
  input logic          rst_n,
  switch_debouncer_if.slave sw
);
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  generate
    if (STABLE_CYCLES < 2 || longint'(STABLE_CYCLES) > CNT_MAX) begin : g_bad_cfg
      $error("switch_debouncer: STABLE_CYCLES out of range for CNT_W");
    end
  endgenerate

  logic [N_SW-1:0] raw_w, db_w, chg_w, counting_w;
  logic            all_stable_q;

  assign raw_w = sw.sw_raw;

  switch_debouncer_lane #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_lane [N_SW-1:0] (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_i     (raw_w),
    .db_o      (db_w),
    .chg_o     (chg_w),
    .counting_o(counting_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) all_stable_q <= 1'b1;
    else        all_stable_q <= ~|counting_w;
  end

  assign sw.sw_db      = db_w;
  assign sw.sw_chg     = chg_w;
  assign sw.all_stable = all_stable_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// Randomised and directed checks of switch_debouncer against a run-length model.
module tb_switch_debouncer;
  localparam int N  = 3;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  switch_debouncer_if #(.N_SW(N)) sw_if();

  switch_debouncer #(.N_SW(N), .STABLE_CYCLES(SC), .CNT_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw_if)
  );

  always #5 clk = ~clk;

  // Model: count consecutive synchronised samples disagreeing with the clean
  // level; SC of them in a row adopt the new level.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_chg = '0;
  logic         m_as = 1'b1;
  int           m_run [N] = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_chg = '0; m_as = 1'b1;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      m_chg = '0;
      m_as  = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (m_s2[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == SC) begin
            m_db[i]  = m_s2[i];
            m_chg[i] = 1'b1;
            m_run[i] = 0;
          end
        end else m_run[i] = 0;
        if (m_run[i] != 0) m_as = 1'b0;
      end
      m_s2 = m_s1;
      m_s1 = sw_if.sw_raw;
    end
  end

  task automatic test_reset();
    sw_if.sw_raw = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({sw_if.sw_db, sw_if.sw_chg, sw_if.all_stable} !== 7'b000_000_1) begin
      fails++;
      $display("FAIL reset_state: got %b expected %b", {sw_if.sw_db, sw_if.sw_chg, sw_if.all_stable}, 7'b000_000_1);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if ({sw_if.sw_db, sw_if.sw_chg, sw_if.all_stable} !== 7'b000_000_1) begin
        fails++;
        $display("FAIL idle_hold cyc%0d: got %b expected %b", k, {sw_if.sw_db, sw_if.sw_chg, sw_if.all_stable}, 7'b000_000_1);
      end
    end
  endtask

  task automatic test_step();
    int rise = -1;
    int nchg = 0;
    sw_if.sw_raw = 3'b001;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if ({sw_if.sw_db, sw_if.sw_chg, sw_if.all_stable} !== {m_db, m_chg, m_as}) begin
        fails++;
        $display("FAIL step_model cyc%0d: got %b expected %b", k, {sw_if.sw_db, sw_if.sw_chg, sw_if.all_stable}, {m_db, m_chg, m_as});
      end
      if (sw_if.sw_db[0] === 1'b1 && rise < 0) rise = k;
      if (sw_if.sw_chg[0] === 1'b1) nchg++;
    end
    checks++;
    if (rise != SC + 1) begin
      fails++;
      $display("FAIL step_latency: got edge %0d expected edge %0d", rise, SC + 1);
    end
    checks++;
    if (nchg != 1) begin
      fails++;
      $display("FAIL step_pulse_count: got %0d expected 1", nchg);
    end
  endtask

  task automatic test_bounce();
    int nchg = 0;
    sw_if.sw_raw[1] = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) sw_if.sw_raw[1] = 1'b0;
      @(negedge clk);
      checks++;
      if ({sw_if.sw_db, sw_if.sw_chg, sw_if.all_stable} !== {m_db, m_chg, m_as}) begin
        fails++;
        $display("FAIL bounce_model cyc%0d: got %b expected %b", k, {sw_if.sw_db, sw_if.sw_chg, sw_if.all_stable}, {m_db, m_chg, m_as});
      end
      if (sw_if.sw_chg[1] === 1'b1 || sw_if.sw_db[1] !== 1'b0) nchg++;
    end
    checks++;
    if (nchg != 0 || sw_if.all_stable !== 1'b1) begin
      fails++;
      $display("FAIL bounce_short_pulse: got hits=%0d all_stable=%b expected hits=0 all_stable=1", nchg, sw_if.all_stable);
    end
  endtask

  task automatic test_toggle();
    int rise = -1;
    int nchg = 0;
    for (int k = 0; k < 10 + 12; k++) begin
      sw_if.sw_raw[2] = (k >= 10) ? 1'b1 : ((k % 2) == 0);
      @(negedge clk);
      checks++;
      if ({sw_if.sw_db, sw_if.sw_chg, sw_if.all_stable} !== {m_db, m_chg, m_as}) begin
        fails++;
        $display("FAIL toggle_model cyc%0d: got %b expected %b", k, {sw_if.sw_db, sw_if.sw_chg, sw_if.all_stable}, {m_db, m_chg, m_as});
      end
      if (sw_if.sw_db[2] === 1'b1 && rise < 0) rise = k - 10;
      if (sw_if.sw_chg[2] === 1'b1) nchg++;
    end
    checks++;
    if (rise != SC + 1 || nchg != 1) begin
      fails++;
      $display("FAIL toggle_qualify: got edge %0d pulses %0d expected edge %0d pulses 1", rise, nchg, SC + 1);
    end
  endtask

  task automatic test_all_channels();
    int           hit = -1;
    logic [N-1:0] hchg = '0, hdb = '0;
    sw_if.sw_raw = '0;
    repeat (12) @(negedge clk);
    checks++;
    if (sw_if.sw_db !== 3'b000) begin
      fails++;
      $display("FAIL all_settle_low: got %b expected 000", sw_if.sw_db);
    end
    sw_if.sw_raw = 3'b111;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if ({sw_if.sw_db, sw_if.sw_chg, sw_if.all_stable} !== {m_db, m_chg, m_as}) begin
        fails++;
        $display("FAIL all_model cyc%0d: got %b expected %b", k, {sw_if.sw_db, sw_if.sw_chg, sw_if.all_stable}, {m_db, m_chg, m_as});
      end
      if (sw_if.sw_chg !== 3'b000 && hit < 0) begin
        hit = k; hchg = sw_if.sw_chg; hdb = sw_if.sw_db;
      end
    end
    checks++;
    if (hit != SC + 1 || hchg !== 3'b111 || hdb !== 3'b111) begin
      fails++;
      $display("FAIL all_same_edge: got edge %0d chg %b db %b expected edge %0d chg 111 db 111", hit, hchg, hdb, SC + 1);
    end
  endtask

  task automatic test_reset_mid();
    int   rise = -1;
    int   nchg = 0;
    sw_if.sw_raw = '0;
    repeat (12) @(negedge clk);
    sw_if.sw_raw = 3'b111;
    repeat (3) @(negedge clk);
    checks++;
    if (sw_if.all_stable !== 1'b0) begin
      fails++;
      $display("FAIL mid_counting: got all_stable %b expected 0", sw_if.all_stable);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sw_if.sw_db, sw_if.sw_chg, sw_if.all_stable} !== 7'b000_000_1) begin
      fails++;
      $display("FAIL mid_reset_immediate: got %b expected %b", {sw_if.sw_db, sw_if.sw_chg, sw_if.all_stable}, 7'b000_000_1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if ({sw_if.sw_db, sw_if.sw_chg, sw_if.all_stable} !== {m_db, m_chg, m_as}) begin
        fails++;
        $display("FAIL mid_model cyc%0d: got %b expected %b", k, {sw_if.sw_db, sw_if.sw_chg, sw_if.all_stable}, {m_db, m_chg, m_as});
      end
      if (sw_if.sw_db === 3'b111 && rise < 0) rise = k;
      if (sw_if.sw_chg !== 3'b000) nchg++;
    end
    checks++;
    if (rise != SC + 1 || nchg != 1) begin
      fails++;
      $display("FAIL mid_requalify: got edge %0d pulses %0d expected edge %0d pulses 1", rise, nchg, SC + 1);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) sw_if.sw_raw = 3'($urandom_range(0, 7));
      @(negedge clk);
      checks++;
      if ({sw_if.sw_db, sw_if.sw_chg, sw_if.all_stable} !== {m_db, m_chg, m_as}) begin
        fails++;
        $display("FAIL random cyc%0d: got %b expected %b", k, {sw_if.sw_db, sw_if.sw_chg, sw_if.all_stable}, {m_db, m_chg, m_as});
      end
    end
  endtask

  initial begin
    sw_if.sw_raw = '0;
    test_reset();
    test_step();
    test_bounce();
    test_toggle();
    test_all_channels();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
